muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the ALU's MULT and DIV operations. Replaces the single-cycle combinational multiply/divide with an iterative radix-2 shift-add multiplier and a restoring divider.
- Sits beside the ALU in the execute stage. The pipeline issues an op through a valid/ready handshake, stalls on busy, and collects the 2*XLEN result (hi/lo) through a response handshake.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 49 ++++
 rtl/muldiv_sequencer.sv | 169 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : ALU op encodings shared with the ALU, plus the multiply/divide
//            sequencer state and step-mode types.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_SRA  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_ADD  = 4'd8;
  localparam logic [3:0] ALU_SUB  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MULT = 4'd12;
  localparam logic [3:0] ALU_DIV  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational iteration of the radix-2 shift-add multiplier
//            or of the restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  step_mode_e      i_mode,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_mul_ext;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_rem_sub;
  logic            w_ge;

  // Multiply: the add is one bit wider so its carry lands in the shifted hi.
  assign w_sum     = {1'b0, i_hi} + {1'b0, i_opd};
  assign w_mul_ext = i_lo[0] ? w_sum : {1'b0, i_hi};

  // Divide: the remainder stays below the divisor, so the difference fits XLEN.
  assign w_rem_sh  = {i_hi, i_lo[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, i_opd});
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - i_opd;

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    if (i_mode == STEP_MUL) begin
      o_hi = w_mul_ext[XLEN:1];
      o_lo = {w_mul_ext[0], i_lo[XLEN-1:1]};
    end else begin
      o_hi = w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle MULT/DIV controller beside the ALU; valid/ready
//            request in, 2*XLEN result out through a response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            busy,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_lo,
  output logic [XLEN-1:0] resp_hi,
  output logic            resp_dbz,
  output logic            resp_illegal
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e       r_state;
  md_state_e       w_state_nxt;

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opd;
  logic [CNT_W-1:0] r_cnt;
  logic            r_dbz;
  logic            r_illegal;

  logic            w_accept;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_b_zero;
  logic            w_last;
  logic            w_done;
  step_mode_e      w_mode;
  logic [XLEN-1:0] w_step_hi;
  logic [XLEN-1:0] w_step_lo;

  assign w_is_mul = (req_op == ALU_MULT);
  assign w_is_div = (req_op == ALU_DIV);
  assign w_b_zero = (req_b == '0);
  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_W'(XLEN - 1));
  assign w_done   = (r_state == S_DONE);
  assign w_mode   = (r_state == S_DIV) ? STEP_DIV : STEP_MUL;

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_mode (w_mode),
    .i_hi   (r_hi),
    .i_lo   (r_lo),
    .i_opd  (r_opd),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_nxt = S_MUL;
          end else if (w_is_div && !w_b_zero) begin
            w_state_nxt = S_DIV;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        // Return to IDLE only; a new request is taken on a later edge.
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_opd     <= '0;
      r_cnt     <= '0;
      r_dbz     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
            if (w_is_mul) begin
              r_hi  <= '0;
              r_lo  <= req_b;
              r_opd <= req_a;
            end else if (w_is_div && !w_b_zero) begin
              r_hi  <= '0;
              r_lo  <= req_a;
              r_opd <= req_b;
            end else if (w_is_div) begin
              r_hi  <= req_a;
              r_lo  <= '1;
              r_opd <= req_b;
              r_dbz <= 1'b1;
            end else begin
              r_hi      <= '0;
              r_lo      <= '0;
              r_opd     <= '0;
              r_illegal <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_hi <= w_step_hi;
          r_lo <= w_step_lo;
          if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Results are only presented while a response is pending.
  assign resp_lo      = w_done ? r_lo : '0;
  assign resp_hi      = w_done ? r_hi : '0;
  assign resp_dbz     = w_done & r_dbz;
  assign resp_illegal = w_done & r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer against an arithmetic
//            reference model (directed cases plus randomized operations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int XLEN = 32;
  localparam logic [3:0] OP_MULT = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;
  localparam logic [3:0] OP_ADD  = 4'd8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      req_op = 4'd0;
  logic [XLEN-1:0] req_a = '0;
  logic [XLEN-1:0] req_b = '0;
  logic            busy;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_lo;
  logic [XLEN-1:0] resp_hi;
  logic            resp_dbz;
  logic            resp_illegal;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .busy         (busy),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_lo      (resp_lo),
    .resp_hi      (resp_hi),
    .resp_dbz     (resp_dbz),
    .resp_illegal (resp_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {illegal, dbz, hi, lo} from plain unsigned arithmetic.
  function automatic logic [65:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    if (op == OP_MULT) begin
      p = 64'(a) * 64'(b);
      return {2'b00, p};
    end else if (op == OP_DIV) begin
      if (b == 0) return {2'b01, a, 32'hFFFF_FFFF};
      return {2'b00, a % b, a / b};
    end
    return {2'b10, 64'd0};
  endfunction

  // Edges after the accept edge until resp_valid is seen.
  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == OP_MULT || (op == OP_DIV && b != 0)) return XLEN;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [65:0] e);
    chk({tag, "_lo"}, resp_lo, e[31:0]);
    chk({tag, "_hi"}, resp_hi, e[63:32]);
    chk({tag, "_dbz"}, resp_dbz, e[64]);
    chk({tag, "_ill"}, resp_illegal, e[65]);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [65:0] e;
    int n;
    e = model(op, a, b);
    chk({tag, "_idle_ready"}, req_ready, 1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_no_ready"}, req_ready, 0);
    wait_resp(n);
    chk({tag, "_latency"}, n, model_lat(op, b));
    repeat (hold) tick();
    chk({tag, "_valid"}, resp_valid, 1);
    check_result(tag, e);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, resp_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    logic [31:0] sa, sb, na, nb, ra, rb, hold_lo, hold_hi;
    logic [3:0]  rop;
    int n, seen;

    // Reset state
    tick();
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_lo", resp_lo, 0);
    chk("rst_hi", resp_hi, 0);
    chk("rst_flags", {resp_dbz, resp_illegal}, 0);
    rst = 1'b0;
    tick();

    // Directed cases
    run_op("mul7x6", OP_MULT, 32'd7, 32'd6, 0);
    run_op("mul_max", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div100_7", OP_DIV, 32'd100, 32'd7, 0);
    run_op("div_max_1", OP_DIV, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, 2);
    run_op("illegal", OP_ADD, 32'd17, 32'd3, 0);

    // Backpressure with competing requests
    sa = 32'd9; sb = 32'd11;
    req_op = OP_MULT; req_a = sa; req_b = sb; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_resp(n);
    chk("bp_latency", n, XLEN);
    hold_lo = resp_lo; hold_hi = resp_hi;
    chk("bp_first_lo", hold_lo, 32'd99);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_op = OP_MULT; req_a = $urandom; req_b = $urandom;
      tick();
      chk("bp_valid_held", resp_valid, 1);
      chk("bp_lo_stable", resp_lo, hold_lo);
      chk("bp_hi_stable", resp_hi, hold_hi);
      chk("bp_no_ready", req_ready, 0);
    end
    na = $urandom; nb = $urandom_range(1, 1000);
    req_op = OP_DIV; req_a = na; req_b = nb; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("bp_new_busy", busy, 1);
    wait_resp(n);
    chk("bp_new_latency", n, XLEN);
    check_result("bp_new", model(OP_DIV, na, nb));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset in the middle of a multiply
    req_op = OP_MULT; req_a = $urandom; req_b = $urandom; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_lo", resp_lo, 0);
    chk("mid_rst_hi", resp_hi, 0);
    seen = 0;
    repeat (40) begin
      tick();
      if (resp_valid) seen++;
    end
    chk("mid_rst_no_stale", seen, 0);
    run_op("mul3x5", OP_MULT, 32'd3, 32'd5, 0);

    // Randomized operations
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    rop = OP_MULT;
        2, 3, 4: rop = OP_DIV;
        default: rop = 4'($urandom_range(0, 11));
      endcase
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
